// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parameterised register file.
// The write-through read path is enabled by REGFILE_BYPASS_EN.
package regfile_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t CLEAR = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: mux, optional write-through, masking.
// The write-through path is compiled in with REGFILE_BYPASS_EN.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         busy,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    input  logic [AW-1:0]                raddr,
    input  logic                         wr_ok,
    input  logic [AW-1:0]                waddr,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata
);

    logic             in_range;
    logic [WIDTH-1:0] rd_val;

    assign in_range = 32'(raddr) < 32'(DEPTH);

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_val = '0;
        if (in_range) begin
            rd_val = mem[raddr];
            if (wr_ok && raddr == waddr)
                rd_val = wdata;
        end
        if (ZERO_REG && raddr == '0)
            rd_val = '0;
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_ok, waddr, wdata};

    always_comb begin
        rd_val = '0;
        if (in_range)
            rd_val = mem[raddr];
        if (ZERO_REG && raddr == '0)
            rd_val = '0;
    end
`endif

    // Output is flushed on the edge after every clearing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (busy)
            rdata <= '0;
        else
            rdata <= rd_val;
    end

endmodule

// File: rtl/regfile_param.sv
// Two-read, one-write register file with a sequential clear engine.
// Define REGFILE_BYPASS_EN for write-through reads.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  DEPTH    = DEF_DEPTH,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t                      state;
    logic [AW-1:0]               clr_idx;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_ok;

    assign busy  = (state == CLEAR);
    assign wr_ok = we && !busy
                && (32'(waddr) < 32'(DEPTH))
                && !(ZERO_REG && waddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    clr_idx <= '0;
                    if (clr_req)
                        state <= CLEAR;
                end
                CLEAR: begin
                    if (clr_idx == LAST) begin
                        state   <= IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; the clear engine initialises it instead.
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_idx] <= '0;
        else if (wr_ok)
            mem[waddr] <= wdata;
    end

    regfile_rdport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd_a (
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .mem   (mem),
        .raddr (raddr_a),
        .wr_ok (wr_ok),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata_a)
    );

    regfile_rdport #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd_b (
        .clk   (clk),
        .rst   (rst),
        .busy  (busy),
        .mem   (mem),
        .raddr (raddr_b),
        .wr_ok (wr_ok),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata_b)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Randomised and directed bench for regfile_param against a cycle model.
// Two instances: default, and DEPTH=6 with ZERO_REG=1.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic       clr_req = 1'b0;
    logic [2:0] waddr = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic       busy0, busy1;

    int n_chk = 0;
    int n_pass = 0;

    int dep[2] = '{8, 6};
    bit zr[2]  = '{1'b0, 1'b1};
    int mem[2][8];
    int rem[2];
    int ea[2];
    int eb[2];

    regfile_param u_dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rd_a0),
        .rdata_b (rd_b0),
        .clr_req (clr_req),
        .busy    (busy0)
    );

    regfile_param #(
        .WIDTH    (8),
        .DEPTH    (6),
        .ZERO_REG (1'b1)
    ) u_dut_z (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rd_a1),
        .rdata_b (rd_b1),
        .clr_req (clr_req),
        .busy    (busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_rd(int i, int a, bit acc);
        if (a >= dep[i])
            return 0;
        if (zr[i] && a == 0)
            return 0;
        if (BYP && acc && a == int'(waddr))
            return int'(wdata);
        return mem[i][a];
    endfunction

    task automatic cycle();
        bit acc;
        #2;
        for (int i = 0; i < 2; i++)
            if (rst)
                rem[i] = dep[i];
        chk("busy0", int'(busy0), int'(rem[0] > 0));
        chk("busy1", int'(busy1), int'(rem[1] > 0));
        for (int i = 0; i < 2; i++) begin
            acc = !rst && rem[i] == 0 && we
               && int'(waddr) < dep[i]
               && !(zr[i] && waddr == 3'd0);
            if (rst || rem[i] > 0) begin
                ea[i] = 0;
                eb[i] = 0;
                if (!rst) begin
                    mem[i][dep[i] - rem[i]] = 0;
                    rem[i]--;
                end
            end else begin
                ea[i] = model_rd(i, int'(raddr_a), acc);
                eb[i] = model_rd(i, int'(raddr_b), acc);
                if (acc)
                    mem[i][waddr] = int'(wdata);
                if (clr_req)
                    rem[i] = dep[i];
            end
        end
        @(posedge clk);
        #1;
        chk("rdata_a0", int'(rd_a0), ea[0]);
        chk("rdata_b0", int'(rd_b0), eb[0]);
        chk("rdata_a1", int'(rd_a1), ea[1]);
        chk("rdata_b1", int'(rd_b1), eb[1]);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++)
            cycle();
    endtask

    task automatic wr(int a, int d);
        we    = 1'b1;
        waddr = 3'(a);
        wdata = 8'(d);
        cycle();
        we    = 1'b0;
    endtask

    task automatic rd(int a, int b);
        raddr_a = 3'(a);
        raddr_b = 3'(b);
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0;
            for (int j = 0; j < 8; j++)
                mem[i][j] = 0;
        end
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(9);
        for (int a = 0; a < 8; a++)
            rd(a, 7 - a);

        wr(3, 8'hA5);
        rd(3, 3);
        idle(1);

        wr(5, 8'h11);
        we = 1'b1; waddr = 3'd5; wdata = 8'h22;
        raddr_a = 3'd5; raddr_b = 3'd5;
        cycle();
        we = 1'b0;
        rd(5, 5);

        we = 1'b1; waddr = 3'd0; wdata = 8'hFF;
        raddr_a = 3'd0; raddr_b = 3'd1;
        cycle();
        we = 1'b0;
        rd(0, 0);

        wr(6, 8'h66);
        wr(7, 8'h67);
        rd(6, 7);

        for (int a = 0; a < 8; a++)
            wr(a, a + 1);
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        idle(2);
        we = 1'b1; waddr = 3'd2; wdata = 8'h77;
        clr_req = 1'b1;
        cycle();
        we = 1'b0;
        clr_req = 1'b0;
        idle(6);
        for (int a = 0; a < 8; a++)
            rd(a, a);

        wr(4, 8'h44);
        we = 1'b1; waddr = 3'd1; wdata = 8'h5A;
        clr_req = 1'b1;
        cycle();
        we = 1'b0;
        clr_req = 1'b0;
        idle(4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(10);
        rd(1, 4);

        for (int k = 0; k < 400; k++) begin
            we      = 1'($urandom % 2);
            waddr   = 3'($urandom);
            wdata   = 8'($urandom);
            raddr_a = 3'($urandom);
            raddr_b = 3'($urandom);
            clr_req = 1'($urandom % 40 == 0);
            rst     = 1'($urandom % 150 == 0);
            cycle();
        end
        rst = 1'b0;
        clr_req = 1'b0;
        we = 1'b0;
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (1..32).
REQ-002 SHALL have parameter DEPTH, default 8, entry count (2..64).
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 = entry 0 hardwired to zero.
REQ-004 SHALL derive localparam AW = clog2(DEPTH), address width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  AW  write address.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have ports raddr_a, raddr_b  input  AW  read addresses, ports A and B.
REQ-011 SHALL have ports rdata_a, rdata_b  output  WIDTH  registered read data.
REQ-012 SHALL have port clr_req  input  1  single-cycle pulse requesting a full clear.
REQ-013 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-014 SHALL write wdata to entry waddr on the rising edge when we=1, busy=0 and waddr<DEPTH.
REQ-015 SHALL present read data one cycle after the address: rdata_x(t+1) = entry[raddr_x(t)].
REQ-016 SHALL return 0 for reads with raddr_x >= DEPTH; such writes are dropped.
REQ-017 SHALL, when ZERO_REG=1, drop writes to entry 0; entry 0 reads 0 in every case, bypass included.
REQ-018 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after index DEPTH-1 is cleared.
REQ-019 SHALL, in CLEAR, zero one entry per cycle at index clr_idx, counting 0 to DEPTH-1; the sequence is exactly DEPTH cycles.
REQ-020 SHALL drive busy=1 for all CLEAR cycles, 0 in IDLE.
REQ-021 SHALL ignore we while busy=1; the write is lost, not queued.
REQ-022 SHALL force rdata_a and rdata_b to 0 on the edge after any busy=1 cycle.
REQ-023 SHALL ignore clr_req while in CLEAR; no restart, no extension.
REQ-024 SHALL resolve clr_req and we in the same IDLE cycle with the write taking effect first; the clear then erases it.
REQ-025 SHALL let both ports read the same address in the same cycle with identical results.

Reset
REQ-026 SHALL, on rst=1, immediately force rdata_a=0, rdata_b=0, clr_idx=0 and state=CLEAR, so busy=1.
REQ-027 SHALL, after rst deasserts, run a full DEPTH-cycle clear before accepting writes; array cells carry no reset.
REQ-028 SHALL restart the clear at index 0 if rst asserts mid-clear.

Configuration
REQ-029 SHALL use macro REGFILE_BYPASS_EN.
REQ-030 SHALL, with REGFILE_BYPASS_EN defined, return wdata on a read whose address equals waddr in a cycle where the write is accepted (write-through), per port.
REQ-031 SHALL, without REGFILE_BYPASS_EN, return the pre-write entry value in that case; the new value is visible from the next read.

Structure
REQ-032 SHALL place the FSM state typedef (IDLE, CLEAR) and the default WIDTH/DEPTH constants in shared package regfile_pkg.
REQ-033 SHALL implement read-port logic (mux, bypass, zero/range masking, output register) once, as sub-module regfile_rdport, instantiated twice.

Verification
REQ-034 Reset: assert rst 2 cycles, release -> busy=1 for exactly 8 cycles (DEPTH=8), then 0; every address reads 0x00.
REQ-035 Write/read: write 0xA5 to addr 3; next cycle raddr_a=3, raddr_b=3 -> both rdata=0xA5 one cycle later.
REQ-036 Same-cycle read/write to addr 5, old 0x11, new 0x22 -> rdata 0x22 with REGFILE_BYPASS_EN, 0x11 without.
REQ-037 ZERO_REG=1: write 0xFF to addr 0 -> reads 0x00; same cycle with bypass -> 0x00.
REQ-038 Clear: fill entries with 0x01..0x08, pulse clr_req -> busy 8 cycles; we=1 with 0x77 at cycle 3 ignored; all entries 0x00 afterwards.
REQ-039 Reset mid-clear at clr_idx=4 -> clear restarts from 0, busy stays high another 8 cycles after release.
